// File: rtl/multicycle_adder.sv
// WIDTH-bit adder that resolves CHUNK bits per clock through a registered inter-chunk carry.
// Define MCA_SUB_EN to add the sub port (A - B as A + ~B + 1).
module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef MCA_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       fsm_state
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [IDX_W-1:0] idx;
    logic             carry;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_sum;
    logic [CHUNK:0]   chain;

`ifdef MCA_SUB_EN
    // Subtraction folds into the adder: invert B once at latch time, force carry-in high.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign chunk_a   = op_a[int'(idx)*CHUNK +: CHUNK];
    assign chunk_b   = op_b[int'(idx)*CHUNK +: CHUNK];
    assign fsm_state = state;

    always_comb begin
        chain     = '0;
        chunk_sum = '0;
        chain[0]  = carry;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_sum[i] = chunk_a[i] ^ chunk_b[i] ^ chain[i];
            chain[i+1]   = (chunk_a[i] & chunk_b[i]) | (chunk_a[i] & chain[i]) |
                           (chunk_b[i] & chain[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b_eff;
                        carry <= cin_eff;
                        idx   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum[int'(idx)*CHUNK +: CHUNK] <= chunk_sum;
                    carry <= chain[CHUNK];
                    if (idx == LAST_IDX) begin
                        // chain[CHUNK-1] is the carry into bit WIDTH-1 on the top chunk.
                        idx   <= '0;
                        cout  <= chain[CHUNK];
                        ovf   <= chain[CHUNK] ^ chain[CHUNK-1];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: 16/4 instance for the main scenarios, 8/8 instance for the single-cycle case.
module tb_multicycle_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
`ifdef MCA_SUB_EN
    logic        sub;
`endif
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [1:0]  fsm_state;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        cin8;
`ifdef MCA_SUB_EN
    logic        sub8;
`endif
    logic        busy8;
    logic        done8;
    logic [7:0]  sum8;
    logic        cout8;
    logic        ovf8;
    logic [1:0]  fsm_state8;

    int errors;
    int checks;

    // Expected {ovf, cout, sum}
    logic [17:0] exp_q[$];
    logic [9:0]  exp8_q[$];

    multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef MCA_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
        .fsm_state(fsm_state)
    );

    multicycle_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef MCA_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8),
        .fsm_state(fsm_state8)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic c);
        logic [16:0] full;
        logic        v;
        full = {1'b0, x} + {1'b0, y} + {16'd0, c};
        v    = (x[15] == y[15]) && (full[15] != x[15]);
        return {v, full[16], full[15:0]};
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y,
                                          input logic c);
        logic [8:0] full;
        logic       v;
        full = {1'b0, x} + {1'b0, y} + {8'd0, c};
        v    = (x[7] == y[7]) && (full[7] != x[7]);
        return {v, full[8], full[7:0]};
    endfunction

    // driver: one-cycle start pulse, expected result pushed at acceptance
    task automatic drive_start(input logic [15:0] op_a, input logic [15:0] op_b,
                               input logic op_cin, input logic op_sub);
        a     = op_a;
        b     = op_b;
        cin   = op_cin;
`ifdef MCA_SUB_EN
        sub   = op_sub;
`endif
        start = 1'b1;
        if (op_sub) exp_q.push_back(model16(op_a, ~op_b, 1'b1));
        else        exp_q.push_back(model16(op_a, op_b, op_cin));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // edges from now until done is seen; 40 means it never came
    task automatic wait_done(output int cycles);
        cycles = 40;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, cout, ovf, sum} !== 20'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {busy, done, cout, ovf, sum});
        end
        checks++;
        if (fsm_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", fsm_state);
        end
        checks++;
        if ({busy8, done8, cout8, ovf8, sum8} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs8: got %h expected 0", {busy8, done8, cout8, ovf8, sum8});
        end
    endtask

    task automatic test_basic();
        logic [17:0] exp;
        drive_start(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_e0: got %b expected 1", busy);
        end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_run_c%0d: got busy=%b done=%b expected busy=1 done=0",
                         k, busy, done);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_edge4: got busy=%b done=%b expected busy=0 done=1", busy, done);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({ovf, cout, sum} !== exp) begin
            errors++;
            $display("FAIL basic_result: got %h expected %h", {ovf, cout, sum}, exp);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || fsm_state !== 2'd0) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%b state=%0d expected done=0 state=0",
                     done, fsm_state);
        end
    endtask

    task automatic test_flags();
        logic [15:0] ta[2];
        logic [15:0] tb_[2];
        logic        tc[2];
        int          cyc;
        logic [17:0] exp;
        ta[0] = 16'h7FFF; tb_[0] = 16'h0001; tc[0] = 1'b0;
        ta[1] = 16'h1234; tb_[1] = 16'h1111; tc[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_start(ta[i], tb_[i], tc[i], 1'b0);
            wait_done(cyc);
            checks++;
            if (cyc != 4) begin
                errors++;
                $display("FAIL flags_latency_%0d: got %0d expected 4", i, cyc);
            end
            exp = exp_q.pop_front();
            checks++;
            if ({ovf, cout, sum} !== exp) begin
                errors++;
                $display("FAIL flags_result_%0d: got %h expected %h", i, {ovf, cout, sum}, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          cyc;
        logic [17:0] exp;
        for (int i = 0; i < 8; i++) begin
            // next start launched in the DONE cycle of the previous add
            drive_start(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                        1'($urandom_range(0, 1)), 1'b0);
            wait_done(cyc);
            checks++;
            if (cyc != 4) begin
                errors++;
                $display("FAIL b2b_latency_%0d: got %0d expected 4", i, cyc);
            end
            exp = exp_q.pop_front();
            checks++;
            if ({ovf, cout, sum} !== exp) begin
                errors++;
                $display("FAIL b2b_result_%0d: got %h expected %h", i, {ovf, cout, sum}, exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_ignored();
        int          cyc;
        int          pulses;
        logic [17:0] exp;
        a     = 16'h0102;
        b     = 16'h0304;
        cin   = 1'b0;
        start = 1'b1;
        exp_q.push_back(model16(16'h0102, 16'h0304, 1'b0));
        @(posedge clk);
        #1;
        a   = 16'h0F0F;
        b   = 16'h1010;
        cin = 1'b1;
        exp_q.push_back(model16(16'h0F0F, 16'h1010, 1'b1));
        pulses = 0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL hold_no_early_done: got %0d pulses expected 0", pulses);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL hold_first_done: got %b expected 1", done);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({ovf, cout, sum} !== exp) begin
            errors++;
            $display("FAIL hold_first_result: got %h expected %h", {ovf, cout, sum}, exp);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || sum !== 16'h0000) begin
            errors++;
            $display("FAIL hold_second_accept: got busy=%b done=%b sum=%h expected busy=1 done=0 sum=0000",
                     busy, done, sum);
        end
        wait_done(cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL hold_second_latency: got %0d expected 4", cyc);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({ovf, cout, sum} !== exp) begin
            errors++;
            $display("FAIL hold_second_result: got %h expected %h", {ovf, cout, sum}, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int pulses;
        a     = 16'h1357;
        b     = 16'h2468;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, cout, ovf, sum} !== 20'd0 || fsm_state !== 2'd0) begin
            errors++;
            $display("FAIL midreset_clear: got outputs=%h state=%0d expected 0 and 0",
                     {busy, done, cout, ovf, sum}, fsm_state);
        end
        #2;
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d active cycles expected 0", pulses);
        end
    endtask

`ifdef MCA_SUB_EN
    task automatic test_subtract();
        int          cyc;
        logic [17:0] exp;
        logic [15:0] sa[2];
        logic [15:0] sb[2];
        sa[0] = 16'h0005; sb[0] = 16'h0007;
        sa[1] = 16'h8000; sb[1] = 16'h0001;
        for (int i = 0; i < 2; i++) begin
            // cin=1 must be ignored while subtracting
            drive_start(sa[i], sb[i], 1'b1, 1'b1);
            wait_done(cyc);
            checks++;
            if (cyc != 4) begin
                errors++;
                $display("FAIL sub_latency_%0d: got %0d expected 4", i, cyc);
            end
            exp = exp_q.pop_front();
            checks++;
            if ({ovf, cout, sum} !== exp) begin
                errors++;
                $display("FAIL sub_result_%0d: got %h expected %h", i, {ovf, cout, sum}, exp);
            end
        end
        sub = 1'b0;
        @(posedge clk);
        #1;
    endtask
`endif

    task automatic test_single_chunk();
        logic [7:0]  xa[2];
        logic [7:0]  xb[2];
        logic        xc[2];
        logic [9:0]  exp;
        xa[0] = 8'h80; xb[0] = 8'h80; xc[0] = 1'b0;
        xa[1] = 8'hFF; xb[1] = 8'h01; xc[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a8     = xa[i];
            b8     = xb[i];
            cin8   = xc[i];
            start8 = 1'b1;
            exp8_q.push_back(model8(xa[i], xb[i], xc[i]));
            @(posedge clk);
            #1;
            start8 = 1'b0;
            checks++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                errors++;
                $display("FAIL w8_busy_%0d: got busy=%b done=%b expected busy=1 done=0",
                         i, busy8, done8);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done8 !== 1'b1 || busy8 !== 1'b0) begin
                errors++;
                $display("FAIL w8_done_%0d: got busy=%b done=%b expected busy=0 done=1",
                         i, busy8, done8);
            end
            exp = exp8_q.pop_front();
            checks++;
            if ({ovf8, cout8, sum8} !== exp) begin
                errors++;
                $display("FAIL w8_result_%0d: got %h expected %h", i, {ovf8, cout8, sum8}, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        cin8   = 1'b0;
`ifdef MCA_SUB_EN
        sub    = 1'b0;
        sub8   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_basic();
        test_flags();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
`ifdef MCA_SUB_EN
        test_subtract();
`endif
        test_single_chunk();
        checks++;
        if (exp_q.size() != 0 || exp8_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left expected 0",
                     exp_q.size(), exp8_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
